// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM states, frame header, error codes.
// Imported by prog_loader and its testbench.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, program RAM write port out.
// slave = loader side, master = host/test side.
interface prog_loader_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled idle cycles since the last clear
// and flags expiry on the LIMIT-th one. Used only with LOADER_TIMEOUT_EN.
module byte_timeout_timer #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = enable && !clear
               && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte stream -> program RAM writer; holds the CPU until a good load.
// Optional inter-byte timeout under macro LOADER_TIMEOUT_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int          AW          = 8,
  parameter int          DW          = 8,
  parameter logic [DW-1:0] HEADER    = DW'(HEADER_DEF),
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          reset_p,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err,
  output logic [1:0]    err_code
);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] csum_total;
  logic          to_expire;

  assign csum_total = acc + bus.rx_data;

`ifdef LOADER_TIMEOUT_EN
  logic to_enable;

  assign to_enable = state inside {ADDR, LEN, DATA, CSUM};

  byte_timeout_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset_p),
    .clear  (bus.rx_valid),
    .enable (to_enable),
    .expire (to_expire)
  );
`else
  // No watchdog: the frame waits forever for its next byte.
  assign to_expire = (TIMEOUT_CYC == 0) && 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_p) begin
    if (!reset_p) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      acc           <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rx_valid && bus.rx_data == HEADER) begin
            state     <= ADDR;
            cpu_hold  <= 1'b1;
            load_busy <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= ERR_NONE;
            acc       <= '0;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
        end
        default: begin
          if (bus.rx_valid) begin
            unique case (state)
              ADDR: begin
                ptr   <= AW'(bus.rx_data);
                state <= LEN;
              end
              LEN: begin
                cnt   <= bus.rx_data;
                state <= (bus.rx_data == '0) ? CSUM : DATA;
              end
              DATA: begin
                acc           <= acc + bus.rx_data;
                cnt           <= cnt - DW'(1);
                ptr           <= ptr + AW'(1);
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= ptr;
                bus.mem_wdata <= bus.rx_data;
                if (cnt == DW'(1)) state <= CSUM;
              end
              CSUM: begin
                load_busy <= 1'b0;
                if (csum_total == '0) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                  cpu_hold  <= 1'b0;
                end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
                  err_code <= ERR_CSUM;
                end
              end
              default: ;
            endcase
          end else if (to_expire) begin
            state     <= ERR;
            load_busy <= 1'b0;
            load_err  <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer for the 4-bit CPU's program memory.
- Takes a framed byte stream from the serial receiver and writes instructions into the program RAM that the CPU control unit later fetches via MAR/MDR.
- Holds the CPU (ring counter and PC) stopped while loading, and releases it only after a good checksum.

Parameters:
- AW, 8, program memory address width.
- DW, 8, instruction/data byte width.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  asynchronous reset, active-low (asserted at 0).
- rx_data  in  DW  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- mem_we  out  1  program RAM write enable, one-cycle pulse.
- mem_addr  out  AW  write address.
- mem_wdata  out  DW  write data.
- cpu_hold  out  1  stops the CPU ring counter and PC while high.
- load_busy  out  1  a frame is in progress.
- load_done  out  1  sticky: last frame completed with a good checksum.
- load_err  out  1  sticky: last frame failed.
- err_code  out  2  00 none, 01 checksum, 10 timeout.

Behaviour:
- Reset (async, reset_p=0):
  - state=IDLE.
  - All outputs 0, including cpu_hold: the CPU runs whatever RAM holds.
  - A reset mid-frame abandons the frame with no further writes; already-written bytes remain.
- Frame format: HEADER, START_ADDR, LEN, LEN data bytes, CSUM.
  - Valid when (sum of data bytes + CSUM) mod 256 == 0.
- States: IDLE -> ADDR -> LEN -> DATA -> CSUM -> DONE | ERR -> IDLE.
- IDLE:
  - rx_valid with rx_data==HEADER -> ADDR.
  - Same edge: cpu_hold=1, load_busy=1, load_done=0, load_err=0, err_code=00, checksum accumulator=0.
  - Any other byte is ignored.
- ADDR: next byte loads the address pointer -> LEN.
- LEN: next byte loads the remaining count.
  - LEN==0 -> CSUM (no writes).
  - Otherwise -> DATA.
- DATA, per accepted byte:
  - accumulator += byte (mod 256); count -= 1.
  - Write registered: if the byte is accepted in cycle k, then in cycle k+1 mem_we=1, mem_addr=pointer, mem_wdata=byte.
  - Pointer increments after each write and wraps mod 2^AW (0xFF -> 0x00).
  - Count reaching 0 -> CSUM.
  - A HEADER value inside a frame is ordinary data; no resync.
- CSUM: next byte checked.
  - (acc + byte) mod 256 == 0 -> DONE.
  - Otherwise -> ERR.
- DONE (1 cycle): load_done=1, cpu_hold=0, load_busy=0 -> IDLE.
- ERR (1 cycle): load_err=1, err_code set, load_busy=0, cpu_hold stays 1 -> IDLE. The CPU remains held until a good frame.
- rx_valid is accepted every cycle, including back-to-back strobes. mem_we is never asserted outside the cycle after an accepted data byte.
- The final data write and the CSUM acceptance may fall in the same cycle; both take effect.
- At most one byte per cycle; rx_valid is ignored in DONE and ERR.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined:
  - A counter resets on every accepted byte and runs while in ADDR/LEN/DATA/CSUM.
  - Reaching TIMEOUT_CYC -> ERR with err_code=10.
  - If a byte arrives in the same cycle as expiry, the byte wins.
- When undefined: no counter; the FSM waits indefinitely and err_code=10 never occurs.

Decomposition:
- Package loader_pkg holds:
  - FSM state enum (IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR).
  - HEADER default.
  - err_code constants ERR_NONE, ERR_CSUM, ERR_TIMEOUT.
- One sub-module: byte_timeout_timer (clear, enable, expire), instantiated only under LOADER_TIMEOUT_EN.

Test Plan:
- Bytes A5,10,03,01,02,03,FA -> mem writes 0x10=01, 0x11=02, 0x12=03, each one cycle after its byte. Then load_done=1, cpu_hold 1->0, err_code=00.
- Same frame with CSUM FB -> three writes occur; then load_err=1, err_code=01, cpu_hold stays 1, load_done=0. Following a good frame, load_err clears and cpu_hold drops.
- A5,FE,03,11,22,33,9A -> writes FE=11, FF=22, 00=33 (wrap), then load_done=1.
- A5,20,00,00 -> no mem_we pulses, load_done=1. Stray bytes 00,5A before the header -> ignored, cpu_hold stays 0.
- LOADER_TIMEOUT_EN with TIMEOUT_CYC=100: A5,10,02,01 then silence -> ERR at 100 cycles after the last byte, err_code=10, cpu_hold=1. Without the macro, same stimulus -> still DATA after 1000 cycles.
- reset_p pulsed low mid-DATA after 1 of 3 bytes -> all outputs 0 immediately. The next data-valued byte is ignored; a fresh frame loads correctly.
